// File: rtl/gs_pkg.sv
// gs_pkg: shared types and constants for the Goldschmidt divider sequencer
package gs_pkg;
  localparam int GS_W = 16;
  localparam int GS_RES_W = 32;
  localparam logic [GS_W-1:0] DIV0_QUOT = 16'hFFFF;
  typedef enum logic [2:0] {
    S_IDLE,
    S_D_SEL,
    S_N_SEL,
    S_HOLD,
    S_CAPTURE,
    S_DONE
  } gs_state_t;
endpackage

// File: rtl/gs_iter_counter.sv
// gs_iter_counter: iteration counter that saturates at ITERS-1 and flags the last iteration
module gs_iter_counter #(
  parameter int ITERS = 3,
  parameter int W = $clog2(ITERS + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] iter,
  output logic         last
);
  logic [W-1:0] cnt_q, cnt_d;
  assign iter = cnt_q;
  assign last = cnt_q == W'(ITERS - 1);
  always_comb cnt_d = clr ? '0 : (inc && !last) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/goldschmidt_ctrl.sv
// goldschmidt_ctrl: accepts a divide request and sequences kSelect/ndSelect for the Goldschmidt datapath
module goldschmidt_ctrl
  import gs_pkg::*;
#(
  parameter int ITERS = 3,
  parameter int RES_LSB = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [GS_W-1:0]     n_in,
  input  logic [GS_W-1:0]     d_in,
  input  logic [GS_W-1:0]     ia_in,
  input  logic [GS_RES_W-1:0] result,
  output logic [GS_W-1:0]     N,
  output logic [GS_W-1:0]     D,
  output logic [GS_W-1:0]     IA,
  output logic                kSelect,
  output logic                ndSelect,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic                div0,
  output logic [GS_W-1:0]     quotient
);
  localparam int IW = $clog2(ITERS + 1);
  gs_state_t state_q, state_d;
  logic [GS_W-1:0] n_q, n_d, d_q, d_d, ia_q, ia_d, quot_q, quot_d;
  logic div0_q, div0_d;
  logic [IW-1:0] iter;
  logic last, accept, zero, unused_res;
  assign accept = ready && start;
  assign zero = d_in == '0;
  assign unused_res = ^result;
  gs_iter_counter #(.ITERS(ITERS), .W(IW)) u_cnt (
    .clk(clk), .reset(reset), .clr(accept), .inc(state_q == S_HOLD),
    .iter(iter), .last(last)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: state_d = accept ? (zero ? S_DONE : S_D_SEL) : S_IDLE;
      S_D_SEL:        state_d = S_N_SEL;
      S_N_SEL:        state_d = S_HOLD;
      S_HOLD:         state_d = last ? S_CAPTURE : S_D_SEL;
      S_CAPTURE:      state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end
  // k only reloads from IA on the first D multiply; every other state keeps k held
  always_comb begin
    ready = state_q == S_IDLE || state_q == S_DONE;
    busy = !ready;
    done = state_q == S_DONE;
    ndSelect = state_q != S_D_SEL;
    kSelect = state_q == S_D_SEL && iter == '0;
  end
  always_comb begin
    n_d = accept ? n_in : n_q;
    d_d = accept ? d_in : d_q;
    ia_d = accept ? ia_in : ia_q;
    div0_d = accept ? zero : div0_q;
    quot_d = (accept && zero) ? DIV0_QUOT :
             state_q == S_CAPTURE ? result[RES_LSB +: GS_W] : quot_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      n_q <= '0;
      d_q <= '0;
      ia_q <= '0;
      quot_q <= '0;
      div0_q <= 1'b0;
    end else begin
      n_q <= n_d;
      d_q <= d_d;
      ia_q <= ia_d;
      quot_q <= quot_d;
      div0_q <= div0_d;
    end
  assign N = n_q;
  assign D = d_q;
  assign IA = ia_q;
  assign div0 = div0_q;
  assign quotient = quot_q;
endmodule

// File: tb/tb_goldschmidt_ctrl.sv
// tb_goldschmidt_ctrl: directed checks of the Goldschmidt sequencer schedule, handshake and corner cases
module tb_goldschmidt_ctrl;
  logic clk = 0, reset = 0, start = 0, start_x = 0;
  logic [15:0] n_in = 0, d_in = 0, ia_in = 0;
  logic [31:0] result = 0;
  logic [15:0] N, D, IA, quotient;
  logic ks, nds, ready, busy, done, div0;
  logic [15:0] n1, d1, ia1, q1, n15, d15, ia15, q15;
  logic k1, nd1, r1, b1, dn1, z1, k15, nd15, r15, b15, dn15, z15;
  int cmp = 0, bad = 0;

  always #5 clk = ~clk;

  goldschmidt_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .n_in(n_in), .d_in(d_in), .ia_in(ia_in),
    .result(result), .N(N), .D(D), .IA(IA), .kSelect(ks), .ndSelect(nds), .ready(ready),
    .busy(busy), .done(done), .div0(div0), .quotient(quotient)
  );
  goldschmidt_ctrl #(.ITERS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start_x), .n_in(n_in), .d_in(d_in), .ia_in(ia_in),
    .result(result), .N(n1), .D(d1), .IA(ia1), .kSelect(k1), .ndSelect(nd1), .ready(r1),
    .busy(b1), .done(dn1), .div0(z1), .quotient(q1)
  );
  goldschmidt_ctrl #(.ITERS(15)) dut15 (
    .clk(clk), .reset(reset), .start(start_x), .n_in(n_in), .d_in(d_in), .ia_in(ia_in),
    .result(result), .N(n15), .D(d15), .IA(ia15), .kSelect(k15), .ndSelect(nd15), .ready(r15),
    .busy(b15), .done(dn15), .div0(z15), .quotient(q15)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    cmp++;
    if ({N, D, IA, quotient} !== 64'h0) begin
      bad++;
      $display("FAIL reset_regs got %h want 0", {N, D, IA, quotient});
    end
    cmp++;
    if ({ks, nds, ready, busy, done, div0} !== 6'b011000) begin
      bad++;
      $display("FAIL reset_ctrl got %b want 011000", {ks, nds, ready, busy, done, div0});
    end
    tick();
    reset = 1;
    tick();
    tick();
    cmp++;
    if ({ready, busy, done} !== 3'b100) begin
      bad++;
      $display("FAIL reset_idle got %b want 100", {ready, busy, done});
    end
  endtask

  task automatic test_divide();
    logic ek, end_, ed, eb;
    n_in = 16'h3000; d_in = 16'h4000; ia_in = 16'h4000;
    start = 1;
    tick();
    start = 0;
    for (int c = 1; c <= 11; c++) begin
      result = (c == 10) ? 32'h1234_5678 : 32'hDEAD_BEEF;
      ek = (c == 1);
      end_ = !(c <= 9 && (c - 1) % 3 == 0);
      ed = (c == 11);
      eb = (c != 11);
      cmp++;
      if ({ks, nds, done, busy} !== {ek, end_, ed, eb}) begin
        bad++;
        $display("FAIL trace c=%0d got k/nd/done/busy=%b want %b", c, {ks, nds, done, busy}, {ek, end_, ed, eb});
      end
      if (c < 11) tick();
    end
    cmp++;
    if (quotient !== 16'h48D1) begin
      bad++;
      $display("FAIL div_quot got %h want 48d1", quotient);
    end
    cmp++;
    if ({N, D, IA} !== {16'h3000, 16'h4000, 16'h4000}) begin
      bad++;
      $display("FAIL div_ops got %h want 300040004000", {N, D, IA});
    end
    tick();
    cmp++;
    if ({done, ready, nds, quotient} !== {3'b011, 16'h48D1}) begin
      bad++;
      $display("FAIL div_after got %h want %h", {done, ready, nds, quotient}, {3'b011, 16'h48D1});
    end
  endtask

  task automatic test_div0();
    n_in = 16'h0007; d_in = 16'h0000; ia_in = 16'h0001;
    start = 1;
    tick();
    start = 0;
    cmp++;
    if ({done, div0, ready, busy, quotient} !== {4'b1110, 16'hFFFF}) begin
      bad++;
      $display("FAIL div0_done got %h want %h", {done, div0, ready, busy, quotient}, {4'b1110, 16'hFFFF});
    end
    tick();
    cmp++;
    if ({done, div0, ready, quotient} !== {3'b011, 16'hFFFF}) begin
      bad++;
      $display("FAIL div0_hold got %h want %h", {done, div0, ready, quotient}, {3'b011, 16'hFFFF});
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    n_in = 16'h1000; d_in = 16'h4000; ia_in = 16'h4000;
    start = 1;
    tick();
    start = 0;
    cmp++;
    if ({div0, busy} !== 2'b01) begin
      bad++;
      $display("FAIL mid_accept got div0/busy=%b want 01", {div0, busy});
    end
    tick(); tick(); tick();
    #2 reset = 0;
    #1;
    cmp++;
    if ({N, D, IA, quotient, ks, nds, ready, busy, done, div0} !== {64'h0, 6'b011000}) begin
      bad++;
      $display("FAIL mid_async got %h", {N, D, IA, quotient, ks, nds, ready, busy, done, div0});
    end
    tick();
    cmp++;
    if ({ready, done, quotient} !== {2'b10, 16'h0}) begin
      bad++;
      $display("FAIL mid_held got %h want %h", {ready, done, quotient}, {2'b10, 16'h0});
    end
    reset = 1;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done) seen = 1;
    end
    cmp++;
    if (seen || !ready) begin
      bad++;
      $display("FAIL mid_nodone got seen_done=%0d ready=%0d want 0 1", seen, ready);
    end
  endtask

  task automatic test_back_to_back();
    result = 32'h1234_5678;
    n_in = 16'h1111; d_in = 16'h2222; ia_in = 16'h3333;
    start = 1;
    tick();
    n_in = 16'hAAAA; d_in = 16'hBBBB; ia_in = 16'hCCCC;
    for (int c = 1; c <= 11; c++) begin
      cmp++;
      if ({N, D, IA, done} !== {48'h1111_2222_3333, c == 11}) begin
        bad++;
        $display("FAIL b2b_first c=%0d got %h", c, {N, D, IA, done});
      end
      tick();
    end
    cmp++;
    if ({N, D, IA, done, busy, nds, ks} !== {48'hAAAA_BBBB_CCCC, 4'b0101}) begin
      bad++;
      $display("FAIL b2b_accept got %h want %h", {N, D, IA, done, busy, nds, ks}, {48'hAAAA_BBBB_CCCC, 4'b0101});
    end
    start = 0;
    for (int c = 13; c <= 22; c++) begin
      tick();
      cmp++;
      if (done !== (c == 22)) begin
        bad++;
        $display("FAIL b2b_second c=%0d got done=%b want %b", c, done, c == 22);
      end
    end
    cmp++;
    if (quotient !== 16'h48D1) begin
      bad++;
      $display("FAIL b2b_quot got %h want 48d1", quotient);
    end
    tick();
  endtask

  task automatic test_ignore();
    result = 32'h0ABC_4000;
    n_in = 16'h5000; d_in = 16'h6000; ia_in = 16'h7000;
    start = 1;
    tick();
    start = 0;
    tick();
    n_in = 16'h0101; d_in = 16'h0202; ia_in = 16'h0303;
    for (int c = 2; c <= 12; c++) begin
      start = (c == 2 || c == 3);
      cmp++;
      if ({N, D, IA, done} !== {48'h5000_6000_7000, c == 11}) begin
        bad++;
        $display("FAIL ign_ops c=%0d got %h", c, {N, D, IA, done});
      end
      if (c < 12) tick();
    end
    start = 0;
    cmp++;
    if ({ready, quotient} !== {1'b1, 16'h2AF1}) begin
      bad++;
      $display("FAIL ign_quot got %h want %h", {ready, quotient}, {1'b1, 16'h2AF1});
    end
  endtask

  task automatic test_iters();
    int c1 = 0, c15 = 0;
    start_x = 1;
    tick();
    start_x = 0;
    for (int c = 1; c <= 60; c++) begin
      if (dn1 && c1 == 0) c1 = c;
      if (dn15 && c15 == 0) c15 = c;
      tick();
    end
    cmp++;
    if (c1 !== 5) begin
      bad++;
      $display("FAIL iters1 got done at %0d want 5", c1);
    end
    cmp++;
    if (c15 !== 47) begin
      bad++;
      $display("FAIL iters15 got done at %0d want 47", c15);
    end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_div0();
    test_reset_mid();
    test_back_to_back();
    test_ignore();
    test_iters();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
